nes_pad_emulator: RTL and testbench

NES_PAD_EMULATOR -- requirements
Module: nes_pad_emulator

---
 rtl/nes_pad_pkg.sv | 43 ++++
 rtl/nes_pad_sync.sv | 45 ++++
 rtl/nes_pad_emulator.sv | 199 +++++++++++++++++++
 tb/tb_nes_pad_emulator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_pkg.sv
// ============================================================================
// nes_pad_pkg
// Shared register offsets, button bit positions and FSM encoding for the
// NES controller emulator.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package nes_pad_pkg;

    localparam int NUM_BUTTONS = 8;
    localparam int IDX_W       = $clog2(NUM_BUTTONS);

    localparam logic [11:0] ADDR_BUTTONS = 12'h000;
    localparam logic [11:0] ADDR_STATUS  = 12'h004;
    localparam logic [11:0] ADDR_TURBO   = 12'h008;

    // Bit positions inside BUTTONS; bit 7 is the first bit shifted out.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } pad_state_e;

    // A programmed turbo period of 0 behaves as 1.
    function automatic logic [3:0] turbo_period(input logic [3:0] raw);
        return (raw == 4'd0) ? 4'd1 : raw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nes_pad_sync.sv
// ============================================================================
// nes_pad_sync
// Multi-flop synchronizer followed by a rise/fall edge detector.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nes_pad_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], i_async};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Both flops clear in reset, so an input already high at release reads as a rise.
    assign o_rise =  sync_q[STAGES-1] & ~prev_q;
    assign o_fall = ~sync_q[STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/nes_pad_emulator.sv
// ============================================================================
// nes_pad_emulator
// APB-programmable NES controller: serialises BUTTONS onto pad_data under the
// console latch/clock. Optional turbo feature: define NES_PAD_TURBO_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module nes_pad_emulator #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        pad_latch,
    input  logic        pad_clock,
    output logic        pad_data
);

    import nes_pad_pkg::*;

    logic latch_rise, latch_fall, clk_rise, clk_fall;

    nes_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk     (PCLK),
        .rst_n   (PRESERN),
        .i_async (pad_latch),
        .o_rise  (latch_rise),
        .o_fall  (latch_fall)
    );

    nes_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clock (
        .clk     (PCLK),
        .rst_n   (PRESERN),
        .i_async (pad_clock),
        .o_rise  (clk_rise),
        .o_fall  (clk_fall)
    );

    pad_state_e             state_q, state_d;
    logic [NUM_BUTTONS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
    logic [15:0]            latch_count_q, latch_count_d;
    logic [31:0]            prdata_q, prdata_d;
    logic [NUM_BUTTONS-1:0] load_val;
    logic [31:0]            rd_mux;
    logic [11:0]            addr;
    logic                   wr_en, rd_setup;

    assign addr     = PADDR[11:0];
    assign wr_en    = PSEL &  PENABLE &  PWRITE;
    assign rd_setup = PSEL & ~PENABLE & ~PWRITE;

`ifdef NES_PAD_TURBO_EN
    logic [11:0] turbo_q, turbo_d;
    logic        phase_q, phase_d;
    logic [3:0]  tcnt_q, tcnt_d;

    // tcnt counts latch rises in the current phase; the phase flips on the
    // rise that follows a full period, so the first frame is never masked.
    always_comb begin
        turbo_d = turbo_q;
        phase_d = phase_q;
        tcnt_d  = tcnt_q;
        if (wr_en && addr == ADDR_TURBO) begin
            turbo_d = PWDATA[11:0];
        end
        if (latch_rise) begin
            if (tcnt_q >= turbo_period(turbo_q[11:8])) begin
                phase_d = ~phase_q;
                tcnt_d  = 4'd1;
            end else begin
                tcnt_d  = tcnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            turbo_q <= '0;
            phase_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            turbo_q <= turbo_d;
            phase_q <= phase_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign load_val = buttons_q & ~(turbo_q[7:0] & {NUM_BUTTONS{phase_q}});

    logic unused_ok;
    assign unused_ok = ^{PADDR[31:12], PWDATA[31:12], clk_fall};
`else
    assign load_val = buttons_q;

    logic unused_ok;
    assign unused_ok = ^{PADDR[31:12], PWDATA[31:8], clk_fall};
`endif

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            ADDR_BUTTONS: rd_mux = {24'd0, buttons_q};
            ADDR_STATUS:  rd_mux = {14'd0, state_q, latch_count_q};
`ifdef NES_PAD_TURBO_EN
            ADDR_TURBO:   rd_mux = {20'd0, turbo_q};
`endif
            default:      rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        buttons_d     = buttons_q;
        latch_count_d = latch_count_q;
        prdata_d      = prdata_q;

        if (wr_en && addr == ADDR_BUTTONS) begin
            buttons_d = PWDATA[NUM_BUTTONS-1:0];
        end
        if (rd_setup) begin
            prdata_d = rd_mux;
        end

        // A latch rise pre-empts everything, including a same-cycle clock rise.
        if (latch_rise) begin
            state_d       = ST_LOAD;
            shift_d       = load_val;
            idx_d         = '0;
            latch_count_d = latch_count_q + 16'd1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    shift_d = load_val;
                    if (latch_fall) begin
                        state_d = ST_SHIFT;
                        idx_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shift_d = {shift_q[NUM_BUTTONS-2:0], 1'b0};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_W'(NUM_BUTTONS - 1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            idx_q         <= '0;
            buttons_q     <= '0;
            latch_count_q <= '0;
            prdata_q      <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            buttons_q     <= buttons_d;
            latch_count_q <= latch_count_d;
            prdata_q      <= prdata_d;
        end
    end

    always_comb begin
        pad_data = 1'b1;
        case (state_q)
            ST_LOAD, ST_SHIFT: pad_data = ~shift_q[NUM_BUTTONS-1];
            ST_DONE:           pad_data = 1'b0;
            default:           pad_data = 1'b1;
        endcase
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_nes_pad_emulator.sv
// ============================================================================
// tb_nes_pad_emulator
// Directed self-checking bench for nes_pad_emulator.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nes_pad_emulator;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        pad_latch = 1'b0, pad_clock = 1'b0;
    logic        pad_data;

    int n_vec = 0;
    int n_err = 0;

    nes_pad_emulator #(.SYNC_STAGES(2)) dut (
        .PCLK      (PCLK),
        .PRESERN   (PRESERN),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .pad_latch (pad_latch),
        .pad_clock (pad_clock),
        .pad_data  (pad_data)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic latch_pulse();
        @(negedge PCLK); pad_latch = 1'b1;
        repeat (4) @(negedge PCLK);
        pad_latch = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    task automatic clock_pulse();
        @(negedge PCLK); pad_clock = 1'b1;
        repeat (4) @(negedge PCLK);
        pad_clock = 1'b0;
        repeat (4) @(negedge PCLK);
    endtask

    // One full frame: each pressed bit must read 0 on pad_data, MSB first.
    task automatic check_frame(input string tag, input logic [7:0] bits);
        latch_pulse();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_bit%0d", tag, i), {31'd0, pad_data}, {31'd0, ~bits[7-i]});
            clock_pulse();
        end
        check($sformatf("%s_done", tag), {31'd0, pad_data}, 32'd0);
    endtask

    logic [31:0] rd;

    initial begin
        // Reset state
        repeat (3) @(negedge PCLK);
        check("rst_pad", {31'd0, pad_data}, 32'd1);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_ready_err", {30'd0, PREADY, PSLVERR}, 32'd2);
        PRESERN = 1'b1;
        apb_read(32'h000, rd); check("rst_buttons", rd, 32'd0);
        apb_read(32'h004, rd); check("rst_status", rd, 32'd0);
        apb_read(32'h008, rd); check("rst_turbo", rd, 32'd0);

        // STATUS is read-only, unmapped offsets read 0, clocks ignored in IDLE
        apb_write(32'h004, 32'hFFFF_FFFF);
        apb_write(32'h00C, 32'h0000_00FF);
        apb_read(32'h004, rd); check("status_ro", rd, 32'd0);
        apb_read(32'h00C, rd); check("unmapped", rd, 32'd0);
        clock_pulse();
        check("idle_clk_pad", {31'd0, pad_data}, 32'd1);
        apb_read(32'h004, rd); check("idle_clk_status", rd, 32'd0);

        // A + Right frame, then a 9th clock held in DONE
        apb_write(32'h000, 32'h81);
        apb_read(32'h000, rd); check("buttons_rb", rd, 32'h81);
        check_frame("f81", 8'h81);
        clock_pulse();
        check("clk9_pad", {31'd0, pad_data}, 32'd0);
        apb_read(32'h004, rd); check("f81_status", rd, 32'h0003_0001);

        // Write during SHIFT leaves the in-flight frame untouched
        apb_write(32'h000, 32'h00);
        latch_pulse();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) apb_write(32'h000, 32'hFF);
            check($sformatf("midwr_bit%0d", i), {31'd0, pad_data}, 32'd1);
            clock_pulse();
        end
        check("midwr_done", {31'd0, pad_data}, 32'd0);
        check_frame("fFF", 8'hFF);

        // Latch and clock rising together: latch wins, index starts at 0
        @(negedge PCLK); pad_latch = 1'b1; pad_clock = 1'b1;
        repeat (4) @(negedge PCLK);
        apb_read(32'h004, rd); check("both_status", rd, 32'h0001_0004);
        check("both_pad", {31'd0, pad_data}, 32'd0);
        pad_latch = 1'b0; pad_clock = 1'b0;
        repeat (4) @(negedge PCLK);
        for (int i = 0; i < 7; i++) clock_pulse();
        apb_read(32'h004, rd); check("both_7clk", rd, 32'h0002_0004);
        clock_pulse();
        apb_read(32'h004, rd); check("both_8clk", rd, 32'h0003_0004);

        // Reset mid-frame
        latch_pulse();
        for (int i = 0; i < 4; i++) clock_pulse();
        check("pre_rst_pad", {31'd0, pad_data}, 32'd0);
        @(negedge PCLK); PRESERN = 1'b0;
        #1 check("midrst_pad", {31'd0, pad_data}, 32'd1);
        check("midrst_prdata", PRDATA, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        apb_read(32'h004, rd); check("midrst_status", rd, 32'd0);
        apb_read(32'h000, rd); check("midrst_buttons", rd, 32'd0);
        apb_write(32'h000, 32'h81);
        check_frame("post_rst", 8'h81);

        // latch_count wrap
        force dut.latch_count_q = 16'hFFFE;
        @(negedge PCLK);
        release dut.latch_count_q;
        latch_pulse();
        apb_read(32'h004, rd); check("cnt_ffff", rd, 32'h0002_FFFF);
        latch_pulse();
        apb_read(32'h004, rd); check("cnt_wrap", rd, 32'h0002_0000);

        // Turbo on A with period 1
        @(negedge PCLK); PRESERN = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESERN = 1'b1;
        apb_write(32'h000, 32'h80);
        apb_write(32'h008, 32'h180);
`ifdef NES_PAD_TURBO_EN
        apb_read(32'h008, rd); check("turbo_rb", rd, 32'h180);
        check_frame("turbo1", 8'h80);
        check_frame("turbo2", 8'h00);
        check_frame("turbo3", 8'h80);
        check_frame("turbo4", 8'h00);
`else
        apb_read(32'h008, rd); check("turbo_rb", rd, 32'd0);
        check_frame("turbo1", 8'h80);
        check_frame("turbo2", 8'h80);
        check_frame("turbo3", 8'h80);
        check_frame("turbo4", 8'h80);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
